// File: rtl/ex_issue_queue_pkg.sv
// rtl/ex_issue_queue_pkg.sv - shared widths, unit codes and entry type for the EX issue queue
package ex_issue_queue_pkg;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 6;
  localparam int UNIT_W = 3;
  localparam int ADDR_W = 32;

  typedef enum logic [UNIT_W-1:0] {
    UNIT_ALU = 3'd0,
    UNIT_MUL = 3'd1,
    UNIT_DIV = 3'd2,
    UNIT_LSU = 3'd3,
    UNIT_BRU = 3'd4
  } ex_unit_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  src1;
    logic [DATA_W-1:0] val1;
    logic [TAG_W-1:0]  src2;
    logic [DATA_W-1:0] val2;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_addr;
  } iq_entry_t;

  // Tag 0 marks an operand that is already valid, so it never matches a broadcast.
  function automatic iq_entry_t cdb_snoop(input iq_entry_t e, input logic cdb_valid,
                                          input logic [TAG_W-1:0] cdb_tag,
                                          input logic [DATA_W-1:0] cdb_data);
    iq_entry_t r;
    r = e;
    if (e.valid && cdb_valid && cdb_tag != '0) begin
      if (e.src1 == cdb_tag) begin
        r.src1 = '0;
        r.val1 = cdb_data;
      end
      if (e.src2 == cdb_tag) begin
        r.src2 = '0;
        r.val2 = cdb_data;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/ex_issue_queue_if.sv
// rtl/ex_issue_queue_if.sv - instruction, CDB and issue signals between pipeline, issue queue and ALU
interface ex_issue_queue_if;
  import ex_issue_queue_pkg::*;

  logic              in_ce;
  logic [UNIT_W-1:0] in_unit;
  logic [OP_W-1:0]   in_op;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_val1;
  logic [DATA_W-1:0] in_val2;
  logic [TAG_W-1:0]  in_src1;
  logic [TAG_W-1:0]  in_src2;
  logic [ADDR_W-1:0] in_target;
  logic [ADDR_W-1:0] in_pc_addr;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              flush;
  logic              full;
  logic              ovf;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_op;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_val1;
  logic [DATA_W-1:0] out_val2;
  logic [ADDR_W-1:0] out_target;
  logic [ADDR_W-1:0] out_pc_addr;

  modport master (
    output in_ce, in_unit, in_op, in_tag, in_val1, in_val2, in_src1, in_src2, in_target,
           in_pc_addr, cdb_valid, cdb_tag, cdb_data, flush, out_ready,
    input  full, ovf, out_valid, out_op, out_tag, out_val1, out_val2, out_target, out_pc_addr
  );

  modport slave (
    input  in_ce, in_unit, in_op, in_tag, in_val1, in_val2, in_src1, in_src2, in_target,
           in_pc_addr, cdb_valid, cdb_tag, cdb_data, flush, out_ready,
    output full, ovf, out_valid, out_op, out_tag, out_val1, out_val2, out_target, out_pc_addr
  );
endinterface

// File: rtl/ex_issue_queue_select.sv
// rtl/ex_issue_queue_select.sv - oldest-ready picker: lowest set index of the ready vector
module ex_issue_select #(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ready,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/ex_issue_queue.sv
// rtl/ex_issue_queue.sv - EX-side collapsing issue queue with CDB snoop; ISSUE_BYPASS_EN enables
// direct queue-bypass into the output register for instructions that arrive ready.
module ex_issue_queue
  import ex_issue_queue_pkg::*;
#(
  parameter int       DEPTH   = 4,
  parameter ex_unit_t UNIT_ID = UNIT_ALU
) (
  input logic              clk,
  input logic              rst,
  ex_issue_queue_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  iq_entry_t        q     [DEPTH];
  iq_entry_t        q_snp [DEPTH];
  iq_entry_t        q_nxt [DEPTH];
  iq_entry_t        in_entry;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_kept;
  logic [CNT_W-1:0] count_nxt;
  logic             ce_q;
  logic [DEPTH-1:0] ready;
  logic             hit;
  logic [IDX_W-1:0] sel;
  logic             accept;
  logic             out_free;
  logic             issue;
  logic             bypass;
  logic             drop;
  logic             insert;

  // Readiness is judged on registered state only; same-cycle CDB captures count next cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ready[i] = q[i].valid && q[i].src1 == '0 && q[i].src2 == '0;
  end

  ex_issue_select #(.DEPTH(DEPTH)) u_select (
    .ready (ready),
    .hit   (hit),
    .idx   (sel)
  );

  always_comb begin
    in_entry = '{valid: 1'b1, op: bus.in_op, tag: bus.in_tag, src1: bus.in_src1,
                 val1: bus.in_val1, src2: bus.in_src2, val2: bus.in_val2,
                 target: bus.in_target, pc_addr: bus.in_pc_addr};
    in_entry = cdb_snoop(in_entry, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    accept   = (bus.in_ce != ce_q) && (bus.in_unit == UNIT_ID) && !bus.flush;
    out_free = !bus.out_valid || bus.out_ready;
    issue    = out_free && hit;
`ifdef ISSUE_BYPASS_EN
    bypass   = accept && out_free && !hit && in_entry.src1 == '0 && in_entry.src2 == '0;
`else
    bypass   = 1'b0;
`endif
    count_kept = issue ? count - CNT_W'(1) : count;
    drop       = accept && !bypass && (count_kept == CNT_W'(DEPTH));
    insert     = accept && !bypass && !drop;
    count_nxt  = insert ? count_kept + CNT_W'(1) : count_kept;
  end

  // Snoop every slot, collapse over the issued slot, then append at the new tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      q_snp[i] = cdb_snoop(q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    for (int i = 0; i < DEPTH - 1; i++)
      q_nxt[i] = (issue && i >= int'(sel)) ? q_snp[i + 1] : q_snp[i];
    q_nxt[DEPTH - 1] = issue ? '0 : q_snp[DEPTH - 1];
    if (insert) begin
      for (int i = 0; i < DEPTH; i++)
        if (count_kept == CNT_W'(i)) q_nxt[i] = in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count           <= '0;
      ce_q            <= 1'b0;
      bus.ovf         <= 1'b0;
      bus.full        <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_op      <= '0;
      bus.out_tag     <= '0;
      bus.out_val1    <= '0;
      bus.out_val2    <= '0;
      bus.out_target  <= '0;
      bus.out_pc_addr <= '0;
    end else begin
      ce_q <= bus.in_ce;
      if (bus.flush) begin
        for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        count         <= '0;
        bus.full      <= 1'b0;
        bus.out_valid <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
        count    <= count_nxt;
        bus.full <= (count_nxt == CNT_W'(DEPTH));
        if (drop) bus.ovf <= 1'b1;
        if (issue || bypass) begin
          bus.out_valid   <= 1'b1;
          bus.out_op      <= issue ? q[sel].op      : in_entry.op;
          bus.out_tag     <= issue ? q[sel].tag     : in_entry.tag;
          bus.out_val1    <= issue ? q[sel].val1    : in_entry.val1;
          bus.out_val2    <= issue ? q[sel].val2    : in_entry.val2;
          bus.out_target  <= issue ? q[sel].target  : in_entry.target;
          bus.out_pc_addr <= issue ? q[sel].pc_addr : in_entry.pc_addr;
        end else if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_issue_queue.sv
// tb/tb_ex_issue_queue.sv - directed plus randomized check of ex_issue_queue against a queue model
module tb_ex_issue_queue;
  import ex_issue_queue_pkg::*;

  localparam int       DEPTH = 4;
  localparam ex_unit_t UID   = UNIT_ALU;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  src1;
    logic [DATA_W-1:0] val1;
    logic [TAG_W-1:0]  src2;
    logic [DATA_W-1:0] val2;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
  } instr_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     vectors = 0;
  int     miscompares = 0;
  instr_t mq[$];
  instr_t mout;
  logic   mvalid, movf, mfull, mce;

  ex_issue_queue_if bus ();

  ex_issue_queue #(.DEPTH(DEPTH), .UNIT_ID(UID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t snoop_m(input instr_t e);
    instr_t r = e;
    if (bus.cdb_valid && bus.cdb_tag != '0) begin
      if (r.src1 == bus.cdb_tag) begin r.src1 = '0; r.val1 = bus.cdb_data; end
      if (r.src2 == bus.cdb_tag) begin r.src2 = '0; r.val2 = bus.cdb_data; end
    end
    return r;
  endfunction

  // One clock of behaviour: oldest ready leaves, broadcasts land, accepted arrival joins the tail.
  task automatic model_step();
    instr_t inc;
    logic   newi, acc, free;
    int     k;
    if (rst) begin
      mq.delete(); mvalid = 1'b0; mout = '0; movf = 1'b0; mfull = 1'b0; mce = 1'b0;
      return;
    end
    newi = (bus.in_ce != mce);
    mce  = bus.in_ce;
    if (bus.flush) begin
      mq.delete(); mvalid = 1'b0; mfull = 1'b0;
      return;
    end
    acc = newi && (bus.in_unit == UID);
    inc = '{op: bus.in_op, tag: bus.in_tag, src1: bus.in_src1, val1: bus.in_val1,
            src2: bus.in_src2, val2: bus.in_val2, target: bus.in_target, pc: bus.in_pc_addr};
    inc = snoop_m(inc);
    k = -1;
    for (int i = 0; i < mq.size(); i++)
      if (k < 0 && mq[i].src1 == '0 && mq[i].src2 == '0) k = i;
    free = !mvalid || bus.out_ready;
    if (free && k >= 0) begin
      mout = mq[k]; mq.delete(k); mvalid = 1'b1;
    end
`ifdef ISSUE_BYPASS_EN
    else if (free && acc && inc.src1 == '0 && inc.src2 == '0) begin
      mout = inc; mvalid = 1'b1; acc = 1'b0;
    end
`endif
    else if (bus.out_ready) mvalid = 1'b0;
    foreach (mq[i]) mq[i] = snoop_m(mq[i]);
    if (acc) begin
      if (mq.size() < DEPTH) mq.push_back(inc);
      else movf = 1'b1;
    end
    mfull = (mq.size() == DEPTH);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("out_valid", 160'(bus.out_valid), 160'(mvalid));
    chk("full", 160'(bus.full), 160'(mfull));
    chk("ovf", 160'(bus.ovf), 160'(movf));
    chk("out_fields",
        160'({bus.out_op, bus.out_tag, bus.out_val1, bus.out_val2, bus.out_target, bus.out_pc_addr}),
        160'({mout.op, mout.tag, mout.val1, mout.val2, mout.target, mout.pc}));
  endtask

  task automatic load_instr(input logic [UNIT_W-1:0] unit, input logic [TAG_W-1:0] tag,
                            input logic [TAG_W-1:0] s1, input logic [DATA_W-1:0] v1,
                            input logic [TAG_W-1:0] s2, input logic [DATA_W-1:0] v2);
    bus.in_ce      = ~bus.in_ce;
    bus.in_unit    = unit;
    bus.in_op      = {2'b10, tag};
    bus.in_tag     = tag;
    bus.in_src1    = s1;
    bus.in_val1    = v1;
    bus.in_src2    = s2;
    bus.in_val2    = v2;
    bus.in_target  = $urandom;
    bus.in_pc_addr = $urandom;
  endtask

  task automatic send(input logic [UNIT_W-1:0] unit, input logic [TAG_W-1:0] tag,
                      input logic [TAG_W-1:0] s1, input logic [DATA_W-1:0] v1,
                      input logic [TAG_W-1:0] s2, input logic [DATA_W-1:0] v2);
    load_instr(unit, tag, s1, v1, s2, v2);
    tick();
  endtask

  task automatic set_cdb(input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    bus.cdb_valid = v;
    bus.cdb_tag   = t;
    bus.cdb_data  = d;
  endtask

  initial begin
    bus.in_ce = 1'b0; bus.in_unit = '0; bus.in_op = '0; bus.in_tag = '0;
    bus.in_val1 = '0; bus.in_val2 = '0; bus.in_src1 = '0; bus.in_src2 = '0;
    bus.in_target = '0; bus.in_pc_addr = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    set_cdb(1'b0, '0, '0);
    rst = 1'b1;
    tick();
    tick();
    chk("reset_out_valid", 160'(bus.out_valid), 160'(0));
    rst = 1'b0;

    // Ready instruction reaches the output two edges after its toggle.
    send(UID, 4'd1, 4'd0, 32'd5, 4'd0, 32'd7);
    chk("lat_e0_idle", 160'(bus.out_valid), 160'(0));
    tick();
    chk("lat_e1_issue", 160'({bus.out_valid, bus.out_val1, bus.out_val2, bus.full}),
        160'({1'b1, 32'd5, 32'd7, 1'b0}));
    tick();

    // Foreign-unit toggle is consumed but ignored.
    send(3'(UNIT_MUL), 4'd2, 4'd0, 32'd1, 4'd0, 32'd2);
    tick();
    chk("foreign_ignored", 160'({bus.out_valid, bus.full}), 160'(0));
    send(UID, 4'd3, 4'd0, 32'd8, 4'd0, 32'd9);
    tick();
    chk("after_foreign", 160'({bus.out_valid, bus.out_tag}), 160'({1'b1, 4'd3}));
    tick();

    // Younger ready instruction overtakes an older one waiting on tag 3.
    send(UID, 4'd1, 4'd3, 32'd0, 4'd0, 32'd2);
    send(UID, 4'd2, 4'd0, 32'd10, 4'd0, 32'd11);
    tick();
    chk("younger_first", 160'({bus.out_valid, bus.out_tag}), 160'({1'b1, 4'd2}));
    set_cdb(1'b1, 4'd3, 32'hAA);
    tick();
    set_cdb(1'b0, '0, '0);
    chk("capture_not_issued", 160'(bus.out_valid), 160'(0));
    tick();
    chk("older_after_capture", 160'({bus.out_valid, bus.out_tag, bus.out_val1}),
        160'({1'b1, 4'd1, 32'hAA}));
    tick();

    // Arrival captures a broadcast in its own cycle.
    set_cdb(1'b1, 4'd9, 32'h55);
    send(UID, 4'd5, 4'd0, 32'd3, 4'd9, 32'd0);
    set_cdb(1'b0, '0, '0);
    tick();
    chk("same_cycle_capture", 160'({bus.out_valid, bus.out_tag, bus.out_val2}),
        160'({1'b1, 4'd5, 32'h55}));
    tick();

    // Fill with waiting entries, overflow, then release them all with one broadcast.
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(UID, 4'(i + 1), 4'd7, 32'(i), (i == 1) ? 4'd7 : 4'd0, 32'(i + 100));
    chk("fill_full", 160'({bus.full, bus.ovf}), 160'({1'b1, 1'b0}));
    send(UID, 4'd9, 4'd0, 32'd1, 4'd0, 32'd1);
    chk("overflow_sticky", 160'({bus.full, bus.ovf}), 160'({1'b1, 1'b1}));
    set_cdb(1'b1, 4'd7, 32'h77);
    tick();
    set_cdb(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("drain_order", 160'({bus.out_valid, bus.out_tag}), 160'({1'b1, 4'(i + 1)}));
      if (i == 1)
        chk("double_capture", 160'({bus.out_val1, bus.out_val2}), 160'({32'h77, 32'h77}));
    end
    chk("drain_not_full", 160'(bus.full), 160'(0));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_cleared", 160'(bus.ovf), 160'(0));

    // Flush discards the queue and the held output; an arrival in that cycle is dropped.
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(UID, 4'(i + 1), 4'd0, 32'(i), 4'd0, 32'(i));
    bus.flush = 1'b1;
    send(UID, 4'd10, 4'd0, 32'd0, 4'd0, 32'd0);
    bus.flush = 1'b0;
    chk("flush_clears", 160'({bus.out_valid, bus.full}), 160'(0));
    bus.out_ready = 1'b1;
    send(UID, 4'd11, 4'd0, 32'd4, 4'd0, 32'd4);
    tick();
    chk("post_flush_issue", 160'({bus.out_valid, bus.out_tag}), 160'({1'b1, 4'd11}));
    tick();

    for (int c = 0; c < 800; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      bus.flush     = ($urandom_range(0, 39) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      set_cdb(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 2) != 0)
        load_instr(($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : UID,
                   4'($urandom_range(1, 15)),
                   ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 3)), $urandom,
                   ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 3)), $urandom);
      tick();
    end
    rst = 1'b0;
    bus.flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
